// File: rtl/test_seq_monitor.sv
// test_seq_monitor: loads, resets, runs and checks N test programs on the core.
// Define TEST_SEQ_STOP_ON_FAIL_EN to end the sequence at the first failure.
module test_seq_monitor #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] END_PC     = 'h1c,
  parameter int              TIMEOUT    = 10000000,
  parameter int              RST_CYCLES = 1,
  parameter int              MAX_TESTS  = 64,
  localparam int             IW = $clog2(MAX_TESTS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IW-1:0]   num_tests,
  output logic            load_req,
  output logic [IW-1:0]   load_idx,
  input  logic            load_ack,
  output logic            cpu_rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] result_val,
  output logic            busy,
  output logic            done,
  output logic            all_pass,
  output logic [IW-1:0]   pass_cnt,
  output logic [IW-1:0]   fail_cnt,
  output logic [IW-1:0]   timeout_cnt,
  output logic [XLEN-1:0] last_result,
  output logic [IW-1:0]   fail_idx
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [IW-1:0] MAX_N     = IW'(MAX_TESTS);
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD, HOLD, RUN, CHECK, NEXT, DONE
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   num_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   pass_q;
  logic [IW-1:0]   fail_q;
  logic [IW-1:0]   tmo_q;
  logic [IW-1:0]   fidx_q;
  logic [XLEN-1:0] last_q;
  logic [CW-1:0]   cnt_q;
  logic [HW-1:0]   hcnt_q;
  logic            load_req_q;
  logic            cpu_rst_q;
  logic            busy_q;
  logic            done_q;

  logic [IW-1:0]   num_clamp;
  logic [IW-1:0]   idx_inc;
  logic            pc_hit;
  logic            res_ok;
  logic            first_fail;

  assign num_clamp  = (num_tests > MAX_N) ? MAX_N : num_tests;
  assign idx_inc    = idx_q + IW'(1);
  assign pc_hit     = (pc == END_PC);
  assign res_ok     = (result_val == '0);
  assign first_fail = (fail_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      tmo_q      <= '0;
      fidx_q     <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      load_req_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_q  <= num_clamp;
            idx_q  <= '0;
            pass_q <= '0;
            fail_q <= '0;
            tmo_q  <= '0;
            fidx_q <= '0;
            last_q <= '0;
            if (num_clamp == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= LOAD;
              done_q     <= 1'b0;
              busy_q     <= 1'b1;
              load_req_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (load_ack) begin
            load_req_q <= 1'b0;
            hcnt_q     <= '0;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (hcnt_q == HOLD_LAST) begin
            cpu_rst_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= RUN;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        RUN: begin
          // End-of-program match wins over a same-cycle timeout
          if (pc_hit) begin
            state_q <= CHECK;
          end else if (cnt_q == CNT_LAST) begin
            fail_q    <= fail_q + 1'b1;
            tmo_q     <= tmo_q + 1'b1;
            cpu_rst_q <= 1'b1;
            if (first_fail) fidx_q <= idx_q;
            if (STOP_ON_FAIL) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= NEXT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CHECK: begin
          last_q    <= result_val;
          cpu_rst_q <= 1'b1;
          if (res_ok) begin
            pass_q  <= pass_q + 1'b1;
            state_q <= NEXT;
          end else begin
            fail_q <= fail_q + 1'b1;
            if (first_fail) fidx_q <= idx_q;
            if (STOP_ON_FAIL) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= NEXT;
            end
          end
        end
        NEXT: begin
          if (idx_inc == num_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q      <= idx_inc;
            load_req_q <= 1'b1;
            state_q    <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_req    = load_req_q;
  assign load_idx    = idx_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign all_pass    = done_q & (fail_q == '0);
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign timeout_cnt = tmo_q;
  assign last_result = last_q;
  assign fail_idx    = fidx_q;

endmodule

// File: doc/test_seq_monitor.md
Name: test_seq_monitor

Overview:
- Synthesizable successor to the single-program pass/fail check in the CPU bench. Sequences N test programs through the core.
- For each program it requests a load, holds the core in reset, then watches the PC for the end address. It checks the result register (zero = pass) and tallies pass, fail and timeout counts.
- Sits beside Top in simulation and FPGA regression builds, and drives Top's reset.

Parameters:
XLEN, 64, width of PC and result value
END_PC, 64'h1c, PC value that marks end of program
TIMEOUT, 10000000, max RUN cycles per program before forced fail
RST_CYCLES, 1, cycles cpu_rst held high after load_ack (min 1)
MAX_TESTS, 64, max programs per sequence; IW = $clog2(MAX_TESTS+1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begins a sequence when idle
num_tests  in  IW  programs in this sequence, sampled on accepted start
load_req  out  1  request loader to place program load_idx into IM/DM
load_idx  out  IW  index of program to load
load_ack  in  1  loader completion; valid only while load_req=1
cpu_rst  out  1  reset to the CPU core
pc  in  XLEN  core's current PC
result_val  in  XLEN  core's result register (x3)
busy  out  1  sequence in progress
done  out  1  sequence finished; sticky until next accepted start
all_pass  out  1  done && fail_cnt==0
pass_cnt  out  IW  programs passed
fail_cnt  out  IW  programs failed, including timeouts
timeout_cnt  out  IW  programs that timed out
last_result  out  XLEN  result_val captured at the last check
fail_idx  out  IW  index of the first failing program; valid when fail_cnt!=0

Behaviour:
- Clock and reset: one clock clk. Asynchronous active-high rst.
- Reset values: all outputs 0 except cpu_rst=1. State=IDLE. Internal cycle counter and index cleared.
- States: IDLE, LOAD, HOLD, RUN, CHECK, NEXT, DONE.
- IDLE/DONE, on start=1:
  - Latch num_tests; clear all counters, last_result, fail_idx and done; load_idx=0.
  - num_tests==0: go directly to DONE (done=1 next cycle, all_pass=1).
  - Otherwise go to LOAD.
  - start while busy is ignored.
- LOAD:
  - load_req=1 and cpu_rst=1; load_idx stable.
  - Hold until load_ack=1. The ack is accepted in the same cycle it is seen; load_req drops the next cycle.
  - Go to HOLD.
- HOLD: cpu_rst=1 for exactly RST_CYCLES cycles, then RUN.
- RUN:
  - cpu_rst=0; cycle counter increments every cycle from 0.
  - pc==END_PC: go to CHECK. The match is evaluated before the timeout check.
  - Otherwise, counter==TIMEOUT-1: timeout. fail_cnt++, timeout_cnt++, fail_idx set if this is the first fail, last_result unchanged. Go to NEXT.
- CHECK (one cycle after the match, letting the final writeback settle):
  - last_result<=result_val.
  - result_val==0: pass_cnt++.
  - Otherwise: fail_cnt++, and fail_idx<=load_idx if fail_cnt was 0.
  - Go to NEXT.
- NEXT:
  - cpu_rst=1.
  - load_idx+1==num_tests: go to DONE.
  - Otherwise load_idx++ and go to LOAD.
- DONE: done=1, busy=0, cpu_rst=1, counters frozen.
- busy=1 in LOAD/HOLD/RUN/CHECK/NEXT.
- Counter width: the cycle counter is $clog2(TIMEOUT) bits and never wraps; it is reset on entry to RUN.
- Reset mid-operation: immediate return to IDLE with reset values. No load_req glitch after release.
- A load_ack seen outside LOAD is ignored.
- num_tests > MAX_TESTS is clamped to MAX_TESTS.

Optional Feature:
- Macro: TEST_SEQ_STOP_ON_FAIL_EN.
- Defined: the first fail (check or timeout) goes straight from CHECK/RUN to DONE. Remaining programs are skipped, and pass_cnt+fail_cnt < num_tests is legal.
- Undefined: all num_tests programs always run.

Test Plan:
- num_tests=3; loader acks 2 cycles after each req; pc reaches 64'h1c 20 cycles into RUN with result_val=0 each time.
  - Required: pass_cnt=3, fail_cnt=0, done=1, all_pass=1.
  - Required: load_idx sequence 0,1,2; cpu_rst high for exactly RST_CYCLES cycles after each ack.
- num_tests=4; program 1 ends with result_val=64'h5, others 0.
  - Required: pass_cnt=3, fail_cnt=1, fail_idx=1, all_pass=0.
  - Required: last_result=0 at done, and 64'h5 after program 1's check.
- TIMEOUT=100; program 0 never reaches END_PC.
  - Required: timeout after exactly 100 RUN cycles; timeout_cnt=1, fail_cnt=1.
  - Required: program 1 still loads (macro undefined).
- Assert rst mid-RUN of program 2 of 5.
  - Required: all counters 0 and cpu_rst=1 asynchronously; IDLE.
  - Required: start after release runs a clean sequence from index 0.
- num_tests=0 start -> done=1 and all_pass=1 one cycle later, load_req never asserted. start pulsed during RUN -> ignored, no counter change.
- TEST_SEQ_STOP_ON_FAIL_EN defined; num_tests=5, program 2 fails.
  - Required: done after program 2; pass_cnt=2, fail_cnt=1, fail_idx=2; load_idx never reaches 3.
